emg_adc_sequencer: RTL and testbench

Synthesisable, parametrised EMG acquisition sequencer. It drives a multichannel ADC front end (analog mux select, VGA gain, ADC enable, start) from one system clock. Scans run over a run-time channel mask with per-channel gain, in continuous (frame-timed) or single-shot mode. The block handshakes on the ADC end-of-conversion, with timeout and overrun reporting. It sits between the system clock domain and the EMG AFE/ADC macro.

---
 rtl/emg_seq_pkg.sv | 17 +
 rtl/emg_ch_picker.sv | 25 ++
 rtl/emg_adc_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_emg_adc_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emg_seq_pkg.sv
// Shared types and constants for the EMG ADC acquisition sequencer.
package emg_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_NEXT    = 2'd3
    } state_e;

    localparam logic MODE_CONT   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    // Extra cycles past the nominal conversion before an EOC is declared missing.
    localparam int TIMEOUT_MARGIN = 2;

endpackage

// File: rtl/emg_ch_picker.sv
// Priority encoder: lowest enabled channel (first=1) or lowest enabled channel above cur.
module emg_ch_picker #(
    parameter int NUM_CH = 16,
    parameter int CH_W   = 4
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              first,
    output logic [CH_W-1:0]   nxt,
    output logic              found
);

    always_comb begin
        nxt   = '0;
        found = 1'b0;
        // Walk downwards so the lowest qualifying index is the one left standing.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt   = CH_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/emg_adc_sequencer.sv
// EMG ADC front-end sequencer: frame/trigger scheduled channel scans with
// settle, conversion handshake on EOC, timeout and overrun reporting.
module emg_adc_sequencer
    import emg_seq_pkg::*;
#(
    parameter int NUM_CH        = 16,
    parameter int CH_W          = 4,
    parameter int GAIN_W        = 3,
    parameter int CONV_CYCLES   = 13,
    parameter int SETTLE_CYCLES = 2,
    parameter int FRAME_W       = 16
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ENABLE,
    input  logic                     MODE,
    input  logic                     SCAN_TRIG,
    input  logic [FRAME_W-1:0]       FRAME_PERIOD,
    input  logic [NUM_CH-1:0]        CH_MASK,
    input  logic [NUM_CH*GAIN_W-1:0] GAIN_TABLE,
    input  logic                     ADC_EOC,
    output logic                     EN_ADC,
    output logic                     START,
    output logic [CH_W-1:0]          CH_SEL,
    output logic [GAIN_W-1:0]        GAIN,
    output logic                     BUSY,
    output logic                     SAMPLE_VALID,
    output logic [CH_W-1:0]          SAMPLE_CH,
    output logic                     FRAME_DONE,
    output logic                     OVERRUN,
    output logic                     TIMEOUT
);

    localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TO_W = $clog2(CONV_CYCLES + TIMEOUT_MARGIN);
    localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST     = TO_W'(CONV_CYCLES + TIMEOUT_MARGIN - 1);

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [ST_W-1:0]     settle_cnt_q, settle_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                busy_q, busy_d;
    logic                start_q, start_d;
    logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
    logic [GAIN_W-1:0]   gain_q, gain_d;
    logic                sample_valid_q, sample_valid_d;
    logic [CH_W-1:0]     sample_ch_q, sample_ch_d;
    logic                frame_done_q, frame_done_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;

    logic                tick;
    logic                scan_req;
    logic                pick_first;
    logic [NUM_CH-1:0]   pick_mask;
    logic [CH_W-1:0]     pick_ch;
    logic                pick_found;

    // Frame timer: free-running 0..FRAME_PERIOD only while enabled in continuous mode.
    always_comb begin
        tick        = 1'b0;
        frame_cnt_d = '0;
        if (ENABLE && (MODE == MODE_CONT)) begin
            if (frame_cnt_q == FRAME_PERIOD) begin
                tick = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
        end
    end

    assign scan_req = tick || ((MODE == MODE_SINGLE) && SCAN_TRIG);

    // In IDLE the scan has not latched its mask yet, so look at the live input.
    assign pick_first = (state_q == S_IDLE);
    assign pick_mask  = pick_first ? CH_MASK : mask_q;

    emg_ch_picker #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_picker (
        .mask  (pick_mask),
        .cur   (ch_sel_q),
        .first (pick_first),
        .nxt   (pick_ch),
        .found (pick_found)
    );

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        settle_cnt_d   = settle_cnt_q;
        to_cnt_d       = to_cnt_q;
        start_d        = 1'b0;
        ch_sel_d       = ch_sel_q;
        gain_d         = gain_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        frame_done_d   = 1'b0;
        timeout_d      = 1'b0;
        overrun_d      = tick && (state_q != S_IDLE);

        if (!ENABLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (scan_req) begin
                        mask_d = CH_MASK;
                        if (pick_found) begin
                            state_d      = S_SETTLE;
                            ch_sel_d     = pick_ch;
                            gain_d       = GAIN_TABLE[int'(pick_ch)*GAIN_W +: GAIN_W];
                            settle_cnt_d = '0;
                        end else begin
                            frame_done_d = 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d  = S_CONVERT;
                        start_d  = 1'b1;
                        to_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + ST_W'(1);
                    end
                end
                S_CONVERT: begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    // EOC on the START cycle belongs to nothing we issued; an EOC on
                    // the last allowed cycle still beats the timeout.
                    if (ADC_EOC && (to_cnt_q != '0)) begin
                        state_d        = S_NEXT;
                        sample_valid_d = 1'b1;
                        sample_ch_d    = ch_sel_q;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d   = S_NEXT;
                        timeout_d = 1'b1;
                    end
                end
                S_NEXT: begin
                    if (pick_found) begin
                        state_d      = S_SETTLE;
                        ch_sel_d     = pick_ch;
                        gain_d       = GAIN_TABLE[int'(pick_ch)*GAIN_W +: GAIN_W];
                        settle_cnt_d = '0;
                    end else begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= S_IDLE;
            frame_cnt_q    <= '0;
            mask_q         <= '0;
            settle_cnt_q   <= '0;
            to_cnt_q       <= '0;
            busy_q         <= 1'b0;
            start_q        <= 1'b0;
            ch_sel_q       <= '0;
            gain_q         <= '0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= '0;
            frame_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            mask_q         <= mask_d;
            settle_cnt_q   <= settle_cnt_d;
            to_cnt_q       <= to_cnt_d;
            busy_q         <= busy_d;
            start_q        <= start_d;
            ch_sel_q       <= ch_sel_d;
            gain_q         <= gain_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            frame_done_q   <= frame_done_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

    assign BUSY         = busy_q;
    assign EN_ADC       = busy_q;
    assign START        = start_q;
    assign CH_SEL       = ch_sel_q;
    assign GAIN         = gain_q;
    assign SAMPLE_VALID = sample_valid_q;
    assign SAMPLE_CH    = sample_ch_q;
    assign FRAME_DONE   = frame_done_q;
    assign OVERRUN      = overrun_q;
    assign TIMEOUT      = timeout_q;

endmodule

// File: tb/tb_emg_adc_sequencer.sv
// Self-checking bench: event timelines from the sequencer compared with a
// cycle-arithmetic model of scans, ticks and the ADC's EOC behaviour.
module tb_emg_adc_sequencer;

    localparam int NCH  = 16;
    localparam int CW   = 4;
    localparam int GW   = 3;
    localparam int CONV = 13;
    localparam int SET  = 2;
    localparam int FW   = 16;
    localparam int K_START = 0, K_SV = 1, K_TO = 2, K_FD = 3, K_OVR = 4;
    localparam int NOCUT = 32'h3fff_ffff;

    logic              CLK = 1'b0, RESET = 1'b1, ENABLE = 1'b0, MODE = 1'b0;
    logic              SCAN_TRIG = 1'b0, ADC_EOC = 1'b0;
    logic [FW-1:0]     FRAME_PERIOD = '0;
    logic [NCH-1:0]    CH_MASK = '0;
    logic [NCH*GW-1:0] GAIN_TABLE = '0;
    logic              EN_ADC, START, BUSY, SAMPLE_VALID, FRAME_DONE, OVERRUN, TIMEOUT;
    logic [CW-1:0]     CH_SEL, SAMPLE_CH;
    logic [GW-1:0]     GAIN;

    emg_adc_sequencer #(
        .NUM_CH(NCH), .CH_W(CW), .GAIN_W(GW), .CONV_CYCLES(CONV),
        .SETTLE_CYCLES(SET), .FRAME_W(FW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .MODE(MODE), .SCAN_TRIG(SCAN_TRIG),
        .FRAME_PERIOD(FRAME_PERIOD), .CH_MASK(CH_MASK), .GAIN_TABLE(GAIN_TABLE),
        .ADC_EOC(ADC_EOC), .EN_ADC(EN_ADC), .START(START), .CH_SEL(CH_SEL), .GAIN(GAIN),
        .BUSY(BUSY), .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE_CH(SAMPLE_CH),
        .FRAME_DONE(FRAME_DONE), .OVERRUN(OVERRUN), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { int cyc; int ch; int gain; } ev_t;
    ev_t   act[5][$];
    ev_t   exp_q[5][$];
    string kname[5] = '{"start", "sample", "timeout", "frame_done", "overrun"};

    int cyc = 0, eoc_due = -1;
    int total = 0, bad = 0;
    int dly[NCH];      // EOC delay after START; 0 = ADC never answers
    bit glitch[NCH];   // spurious EOC on the START cycle itself
    int gtab[NCH];

    function automatic ev_t mk(input int c, input int ch, input int g);
        ev_t e;
        e.cyc = c; e.ch = ch; e.gain = g;
        return e;
    endfunction

    // ADC model: answers the most recent START after its configured delay.
    always @(posedge CLK) begin
        cyc++;
        #1;
        ADC_EOC = (cyc == eoc_due);
    end

    always @(negedge CLK) begin
        if (!RESET) begin
            if (START) begin
                act[K_START].push_back(mk(cyc, int'(CH_SEL), int'(GAIN)));
                eoc_due = (dly[CH_SEL] == 0) ? -1 : cyc + dly[CH_SEL];
                if (glitch[CH_SEL]) ADC_EOC = 1'b1;
            end
            if (SAMPLE_VALID) act[K_SV].push_back(mk(cyc, int'(SAMPLE_CH), 0));
            if (TIMEOUT)      act[K_TO].push_back(mk(cyc, 0, 0));
            if (FRAME_DONE)   act[K_FD].push_back(mk(cyc, 0, 0));
            if (OVERRUN)      act[K_OVR].push_back(mk(cyc, 0, 0));
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_exp(input int k, input int c, input int ch, input int g);
        exp_q[k].push_back(mk(c, ch, g));
    endtask

    task automatic set_gains();
        for (int i = 0; i < NCH; i++) GAIN_TABLE[i*GW +: GW] = GW'(gtab[i]);
    endtask

    // One scan started at cycle t: settle, convert, answer-or-timeout, next.
    task automatic scan_model(input int t, input logic [NCH-1:0] m, output int fd);
        int s, nx;
        if (m == '0) begin
            fd = t + 1;
            push_exp(K_FD, fd, 0, 0);
            return;
        end
        s  = t + 1 + SET;
        nx = t;
        for (int ch = 0; ch < NCH; ch++) begin
            if (m[ch]) begin
                push_exp(K_START, s, ch, gtab[ch]);
                if (dly[ch] >= 1 && dly[ch] <= CONV + 1) begin
                    nx = s + dly[ch] + 1;
                    push_exp(K_SV, nx, ch, 0);
                end else begin
                    nx = s + CONV + 2;
                    push_exp(K_TO, nx, 0, 0);
                end
                s = nx + 1 + SET;
            end
        end
        fd = nx + 1;
        push_exp(K_FD, fd, 0, 0);
    endtask

    // Continuous mode enabled at cycle e, disabled at cycle a.
    task automatic cont_model(input int e, input int p, input int a, input logic [NCH-1:0] m);
        int idle_from, fd;
        idle_from = e;
        for (int c = e + p; c < a; c += p + 1) begin
            if (c >= idle_from) begin
                scan_model(c, m, fd);
                idle_from = fd;
            end else begin
                push_exp(K_OVR, c + 1, 0, 0);
            end
        end
    endtask

    task automatic check_events(input int cut);
        for (int k = 0; k < 5; k++) begin
            while (exp_q[k].size() > 0 && exp_q[k][$].cyc > cut) void'(exp_q[k].pop_back());
            chk($sformatf("%s count", kname[k]), act[k].size(), exp_q[k].size());
            for (int i = 0; i < act[k].size() && i < exp_q[k].size(); i++) begin
                chk($sformatf("%s[%0d] cycle", kname[k], i), act[k][i].cyc, exp_q[k][i].cyc);
                if (k == K_START || k == K_SV)
                    chk($sformatf("%s[%0d] ch", kname[k], i), act[k][i].ch, exp_q[k][i].ch);
                if (k == K_START)
                    chk($sformatf("%s[%0d] gain", kname[k], i), act[k][i].gain, exp_q[k][i].gain);
            end
            act[k].delete();
            exp_q[k].delete();
        end
    endtask

    task automatic single(input logic [NCH-1:0] m, input bit mid_trig);
        int t, fd;
        t = cyc;
        CH_MASK = m;
        SCAN_TRIG = 1'b1;
        at(t + 1);
        SCAN_TRIG = 1'b0;
        CH_MASK = NCH'($urandom());
        scan_model(t, m, fd);
        if (mid_trig && fd > t + 30) begin
            at(t + 20);
            SCAN_TRIG = 1'b1;
            at(t + 21);
            SCAN_TRIG = 1'b0;
        end
        at(fd + 2);
        check_events(NOCUT);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, int'(BUSY), 0);
        chk({tag, " en_adc"}, int'(EN_ADC), 0);
        chk({tag, " start"}, int'(START), 0);
        chk({tag, " ch_sel"}, int'(CH_SEL), 0);
        chk({tag, " gain"}, int'(GAIN), 0);
        chk({tag, " sample_valid"}, int'(SAMPLE_VALID), 0);
        chk({tag, " sample_ch"}, int'(SAMPLE_CH), 0);
        chk({tag, " frame_done"}, int'(FRAME_DONE), 0);
        chk({tag, " overrun"}, int'(OVERRUN), 0);
        chk({tag, " timeout"}, int'(TIMEOUT), 0);
    endtask

    initial begin
        int e, a, t, fd, last_ch, last_g;
        for (int i = 0; i < NCH; i++) begin
            gtab[i] = i % 8; dly[i] = CONV; glitch[i] = 1'b0;
        end
        set_gains();

        repeat (2) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RESET = 1'b0;
        at(cyc + 2);

        // Continuous, long frame: two full scans, 600 cycles apart.
        FRAME_PERIOD = 16'd599; CH_MASK = 16'hFFFF; MODE = 1'b0; ENABLE = 1'b1;
        e = cyc;
        a = e + 599 + 600 + 400;
        cont_model(e, 599, a, 16'hFFFF);
        at(a);
        ENABLE = 1'b0;
        at(a + 3);
        check_events(a);

        // Continuous, short frame: overruns during scans, abort mid third scan.
        glitch[4] = 1'b1; glitch[9] = 1'b1;
        FRAME_PERIOD = 16'd99; ENABLE = 1'b1;
        e = cyc;
        a = e + 99 + 650;
        cont_model(e, 99, a, 16'hFFFF);
        last_ch = -1; last_g = -1;
        foreach (exp_q[K_START][i])
            if (exp_q[K_START][i].cyc <= a) begin
                last_ch = exp_q[K_START][i].ch; last_g = exp_q[K_START][i].gain;
            end
        at(a);
        ENABLE = 1'b0;
        at(a + 1);
        @(negedge CLK);
        chk("abort busy", int'(BUSY), 0);
        chk("abort en_adc", int'(EN_ADC), 0);
        chk("abort start", int'(START), 0);
        chk("abort ch_sel hold", int'(CH_SEL), last_ch);
        chk("abort gain hold", int'(GAIN), last_g);
        at(a + 40);
        check_events(a);
        glitch[4] = 1'b0; glitch[9] = 1'b0;

        // Single-shot directed cases.
        MODE = 1'b1; ENABLE = 1'b1;
        at(cyc + 3);
        single(16'h8421, 1'b1);
        dly[3] = 0;
        single(16'hFFFF, 1'b1);
        dly[3] = CONV;

        t = cyc;
        CH_MASK = '0;
        SCAN_TRIG = 1'b1;
        scan_model(t, '0, fd);
        at(t + 1);
        SCAN_TRIG = 1'b0;
        @(negedge CLK);
        chk("zero mask frame_done", int'(FRAME_DONE), 1);
        chk("zero mask busy", int'(BUSY), 0);
        at(t + 20);
        check_events(NOCUT);

        // Randomised single-shot scans.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NCH; i++) begin
                gtab[i]   = $urandom_range(0, 7);
                dly[i]    = $urandom_range(0, CONV + 4);
                glitch[i] = ($urandom_range(0, 5) == 0);
            end
            set_gains();
            single(NCH'($urandom()), ($urandom_range(0, 1) == 1));
        end

        // Asynchronous reset in the middle of a conversion.
        for (int i = 0; i < NCH; i++) begin
            gtab[i] = (i % 7) + 1; dly[i] = CONV; glitch[i] = 1'b0;
        end
        set_gains();
        t = cyc;
        CH_MASK = 16'hFFE0;
        SCAN_TRIG = 1'b1;
        scan_model(t, 16'hFFE0, fd);
        at(t + 1);
        SCAN_TRIG = 1'b0;
        at(t + 6);
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1 chk_all_zero("async reset");
        check_events(t + 6);
        at(cyc + 2);
        RESET = 1'b0;
        at(cyc + 3);
        chk("post reset busy", int'(BUSY), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
